// File: rtl/hilo_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_if
//  Description : Bundle between the pipeline (EX/WB side) and the HI/LO unit.
//                Carries the writeback HI/LO write, the divide request from
//                EX, the flush, and the committed HI/LO plus stall/done status
//                returned by the unit.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    we_i, hi_i, lo_i              writeback HI/LO write
//    div_start_i, div_signed_i     divide request (level) and DIV/DIVU select
//    dividend_i, divisor_i         rs / rt operands
//    annul_i                       flush of the instruction owning the divide
//    hi_o, lo_o                    committed HI / LO
//    stall_req_o                   stall request to the stall controller
//    div_done_o                    one-cycle divide completion pulse
//  Modports: master = pipeline side, slave = hilo_unit
// ============================================================================
interface hilo_if;
    logic        we_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        div_start_i;
    logic        div_signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_req_o;
    logic        div_done_o;

    modport master (
        output we_i, hi_i, lo_i, div_start_i, div_signed_i,
               dividend_i, divisor_i, annul_i,
        input  hi_o, lo_o, stall_req_o, div_done_o
    );

    modport slave (
        input  we_i, hi_i, lo_i, div_start_i, div_signed_i,
               dividend_i, divisor_i, annul_i,
        output hi_o, lo_o, stall_req_o, div_done_o
    );
endinterface
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_unit
//  Description : Architectural HI/LO register pair with a 32-cycle restoring
//                radix-2 divider (DIV/DIVU). Accepts writeback HI/LO writes,
//                runs divisions handed over by EX while stalling the
//                pipeline, and drives the committed HI/LO values.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   system clock, rising edge
//    rst   in   asynchronous, active-low reset
//    bus   slave modport of hilo_if (see hilo_if.sv for the signal list)
// ============================================================================
module hilo_unit (
    input  logic   clk,
    input  logic   rst,
    hilo_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    state_t      r_state;
    logic [4:0]  r_cnt;
    // {rem, quot}. The 65th bit of the algorithm only exists in the shifted
    // combinational view: the stored remainder is always below the divisor,
    // so it fits in 32 bits between steps.
    logic [63:0] r_shreg;
    logic [31:0] r_divisor;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start;
    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [31:0] w_dvd_abs;
    logic [31:0] w_dvs_abs;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_next;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_wr;

    assign w_start   = (r_state == ST_IDLE) && bus.div_start_i && !bus.annul_i;

    // Signed mode works on magnitudes; abs(0x80000000) wraps back to
    // 0x80000000, which is the right magnitude when read as unsigned.
    assign w_dvd_neg = bus.div_signed_i && bus.dividend_i[31];
    assign w_dvs_neg = bus.div_signed_i && bus.divisor_i[31];
    assign w_dvd_abs = w_dvd_neg ? (32'd0 - bus.dividend_i) : bus.dividend_i;
    assign w_dvs_abs = w_dvs_neg ? (32'd0 - bus.divisor_i)  : bus.divisor_i;

    // One restoring step: shift {rem,quot} left, trial-subtract the divisor
    // from the 33-bit shifted remainder. When the subtraction succeeds the
    // true difference is below 2^32, so a 32-bit subtract is exact.
    assign w_rem_sh  = r_shreg[63:31];
    assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});
    assign w_diff    = w_rem_sh[31:0] - r_divisor;
    assign w_next    = {(w_ge ? w_diff : w_rem_sh[31:0]), r_shreg[30:0], w_ge};

    assign w_quot    = r_q_neg ? (32'd0 - r_shreg[31:0])  : r_shreg[31:0];
    assign w_rem     = r_r_neg ? (32'd0 - r_shreg[63:32]) : r_shreg[63:32];

    // A flushed division neither writes nor pulses done.
    assign w_div_wr  = (r_state == ST_END) && !bus.annul_i;

    assign bus.hi_o        = r_hi;
    assign bus.lo_o        = r_lo;
    assign bus.div_done_o  = ((r_state == ST_END) || (r_state == ST_BYZERO))
                             && !bus.annul_i;
    // Released in END so the stalled instruction advances in the cycle its
    // result is written; forced low while reset is held.
    assign bus.stall_req_o = rst && (w_start || (r_state == ST_BYZERO)
                                             || (r_state == ST_ON));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 5'd0;
            r_shreg   <= 64'd0;
            r_divisor <= 32'd0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_shreg   <= {32'd0, w_dvd_abs};
                        r_divisor <= w_dvs_abs;
                        r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg   <= w_dvd_neg;
                        r_cnt     <= 5'd0;
                        r_state   <= (bus.divisor_i == 32'd0) ? ST_BYZERO : ST_ON;
                    end
                end
                ST_BYZERO: begin
                    r_state <= ST_IDLE;
                end
                ST_ON: begin
                    if (bus.annul_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_shreg <= w_next;
                        r_cnt   <= r_cnt + 5'd1;
                        if (r_cnt == c_LAST_STEP) begin
                            r_state <= ST_END;
                        end
                    end
                end
                ST_END: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // The division belongs to the younger instruction, so its result
            // wins over a writeback write landing in the same cycle.
            if (w_div_wr) begin
                r_hi <= w_rem;
                r_lo <= w_quot;
            end else if (bus.we_i) begin
                r_hi <= bus.hi_i;
                r_lo <= bus.lo_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_unit
//  Description : Directed self-checking bench for hilo_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hilo_if bus ();

    hilo_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled a few time units later, mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Cycle 0 = start seen in IDLE, 1..32 = ON, 33 = END, 34 = result visible.
    task automatic run_div(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic inject_we);
        step();
        bus.div_start_i  = 1'b1;
        bus.div_signed_i = sgn;
        bus.dividend_i   = a;
        bus.divisor_i    = b;
        #3 chk1({tag, " stall c0"}, bus.stall_req_o, 1'b1);
        step();
        bus.div_start_i = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            #3;
            chk1({tag, " stall on"}, bus.stall_req_o, 1'b1);
            chk1({tag, " done on"}, bus.div_done_o, 1'b0);
            step();
        end
        if (inject_we) begin
            bus.we_i = 1'b1;
            bus.hi_i = 32'h0000AAAA;
            bus.lo_i = 32'h0000BBBB;
        end
        #3;
        chk1({tag, " done c33"}, bus.div_done_o, 1'b1);
        chk1({tag, " stall c33"}, bus.stall_req_o, 1'b0);
        step();
        bus.we_i = 1'b0;
        #3;
        chk1({tag, " done c34"}, bus.div_done_o, 1'b0);
        chk32({tag, " lo"}, bus.lo_o, exp_lo);
        chk32({tag, " hi"}, bus.hi_o, exp_hi);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.we_i         = 1'b0;
        bus.hi_i         = 32'd0;
        bus.lo_i         = 32'd0;
        bus.div_start_i  = 1'b1;
        bus.div_signed_i = 1'b0;
        bus.dividend_i   = 32'd100;
        bus.divisor_i    = 32'd7;
        bus.annul_i      = 1'b0;

        // Reset state, with a divide request present during reset.
        #2;
        chk32("rst hi", bus.hi_o, 32'd0);
        chk32("rst lo", bus.lo_o, 32'd0);
        chk1("rst stall", bus.stall_req_o, 1'b0);
        chk1("rst done", bus.div_done_o, 1'b0);
        bus.div_start_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();
        #3;
        chk32("rel hi", bus.hi_o, 32'd0);
        chk32("rel lo", bus.lo_o, 32'd0);
        chk1("rel stall", bus.stall_req_o, 1'b0);

        // Writeback write, one-edge latency.
        step();
        bus.we_i = 1'b1;
        bus.hi_i = 32'h12345678;
        bus.lo_i = 32'h9ABCDEF0;
        #3 chk32("we hi pre", bus.hi_o, 32'd0);
        step();
        bus.we_i = 1'b0;
        #3;
        chk32("we hi", bus.hi_o, 32'h12345678);
        chk32("we lo", bus.lo_o, 32'h9ABCDEF0);

        // Divisions.
        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("divu ffff/1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
        run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        run_div("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);

        // Divide by zero with HI/LO preloaded.
        step();
        bus.we_i = 1'b1;
        bus.hi_i = 32'h11;
        bus.lo_i = 32'h22;
        step();
        bus.we_i         = 1'b0;
        bus.div_start_i  = 1'b1;
        bus.div_signed_i = 1'b0;
        bus.dividend_i   = 32'd5;
        bus.divisor_i    = 32'd0;
        #3;
        chk1("dz stall c0", bus.stall_req_o, 1'b1);
        chk1("dz done c0", bus.div_done_o, 1'b0);
        step();
        bus.div_start_i = 1'b0;
        #3;
        chk1("dz done c1", bus.div_done_o, 1'b1);
        chk1("dz stall c1", bus.stall_req_o, 1'b1);
        step();
        #3;
        chk1("dz done c2", bus.div_done_o, 1'b0);
        chk1("dz stall c2", bus.stall_req_o, 1'b0);
        chk32("dz hi", bus.hi_o, 32'h11);
        chk32("dz lo", bus.lo_o, 32'h22);

        // Annul during ON at cycle 10.
        step();
        bus.div_start_i = 1'b1;
        bus.dividend_i  = 32'd100;
        bus.divisor_i   = 32'd7;
        #3 chk1("an stall c0", bus.stall_req_o, 1'b1);
        step();
        bus.div_start_i = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #3 chk1("an stall on", bus.stall_req_o, 1'b1);
            step();
        end
        bus.annul_i = 1'b1;
        #3;
        chk1("an stall c10", bus.stall_req_o, 1'b1);
        chk1("an done c10", bus.div_done_o, 1'b0);
        step();
        bus.annul_i = 1'b0;
        #3;
        chk1("an stall c11", bus.stall_req_o, 1'b0);
        for (int c = 0; c < 30; c++) begin
            step();
            #3;
            chk1("an done after", bus.div_done_o, 1'b0);
            chk1("an stall after", bus.stall_req_o, 1'b0);
        end
        chk32("an hi", bus.hi_o, 32'h11);
        chk32("an lo", bus.lo_o, 32'h22);

        // we_i in the END cycle loses to the division result.
        run_div("divu end+we", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

        // Asynchronous reset in the middle of ON.
        step();
        bus.div_start_i = 1'b1;
        bus.dividend_i  = 32'd100;
        bus.divisor_i   = 32'd7;
        step();
        bus.div_start_i = 1'b0;
        repeat (4) step();
        #3 rst = 1'b0;
        #1;
        chk32("ar hi", bus.hi_o, 32'd0);
        chk32("ar lo", bus.lo_o, 32'd0);
        chk1("ar stall", bus.stall_req_o, 1'b0);
        chk1("ar done", bus.div_done_o, 1'b0);
        step();
        #3 rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            #3 chk1("ar done after", bus.div_done_o, 1'b0);
        end
        chk32("ar hi end", bus.hi_o, 32'd0);
        chk32("ar lo end", bus.lo_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_unit.md
# hilo_unit

Architectural HI/LO register pair plus a 32-cycle iterative divider, sitting beside the execute stage of the 5-stage MIPS pipeline. It is the write-side end of the HI/LO interface:
- it accepts the `whilo`/`hi`/`lo` writes that reach writeback;
- it runs DIV/DIVU handed over by EX, stalling the pipeline while it runs;
- it drives the committed `hi_o`/`lo_o` values that EX reads and forwards.

## Interface
- No parameters; all data paths are 32 bits.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- we_i  in  1  writeback HI/LO write enable (MTHI/MTLO/MULT results)
- hi_i  in  32  writeback HI data
- lo_i  in  32  writeback LO data
- div_start_i  in  1  EX requests a division (level, held while stalled)
- div_signed_i  in  1  1 = DIV (two's complement), 0 = DIVU
- dividend_i  in  32  rs operand
- divisor_i  in  32  rt operand
- annul_i  in  1  flush: abandon the division in progress, no HI/LO write
- hi_o  out  32  committed HI register
- lo_o  out  32  committed LO register
- stall_req_o  out  1  pipeline stall request to the stall controller
- div_done_o  out  1  one-cycle pulse: the division result is written this cycle

## Operation
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - If div_start_i=1 and annul_i=0, latch the operands and the signed flag.
  - If the divisor is 0, go to BYZERO; otherwise go to ON with cnt=0.
  - Signed mode latches absolute values and records quotient sign = dividend[31]^divisor[31] and remainder sign = dividend[31].
- ON:
  - Restoring radix-2 step per cycle on a 65-bit {rem,quot} shift register.
  - Each step: shift left 1; if rem[63:32] >= divisor, subtract and set quot bit 0.
  - cnt increments each step; after the step with cnt=31, go to END.
- END:
  - Apply the signs: the quotient is negated when its sign flag is 1; the remainder is negated when its flag is 1.
  - Write LO=quotient and HI=remainder, pulse div_done_o, go to IDLE.
- BYZERO: for one cycle, pulse div_done_o with no HI/LO write (the result is architecturally undefined; HI/LO are left unchanged), then go to IDLE.
- Unsigned mode uses the operands as-is. abs(0x80000000) = 0x80000000, treated unsigned.
- annul_i=1 in BYZERO or ON forces IDLE on the next edge: no write, no div_done_o. In END, annul_i suppresses the write and the pulse.
- HI/LO write priority: div result (END) > we_i. A simultaneous we_i write in the END cycle is discarded, because the division belongs to the younger instruction.
- we_i in any other cycle writes hi_i/lo_i on that edge.
- div_start_i is ignored outside IDLE. A new division requires div_start_i to be seen in IDLE again.
- stall_req_o is combinational:
  - 1 when (IDLE and div_start_i and !annul_i), or in BYZERO, or in ON.
  - 0 in END, so the stalled instruction advances in the same cycle its result is written.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, hi_o=lo_o=0, div_done_o=0, internal dividend/divisor/flags=0. stall_req_o=0 during reset, independent of the inputs.
- Reset during ON or END aborts the division with no write.
- we_i write latency: 1 edge. Data sampled at edge k is visible on hi_o/lo_o after edge k. There is no combinational bypass; EX forwards from MEM/WB.
- Division latency: start seen in IDLE at cycle 0 → ON for cycles 1–32 → END at cycle 33.
  - div_done_o=1 during cycle 33.
  - The new HI/LO is visible from cycle 34.
  - stall_req_o=1 for cycles 0–32.
- Divide-by-zero: start at cycle 0 → BYZERO at cycle 1 with div_done_o=1 and stall_req_o=1 → IDLE at cycle 2 with stall_req_o=0.
- Back-to-back divisions: if div_start_i is high in the IDLE cycle after END, a new division starts with no bubble.

## Test plan
- Reset, then release: hi_o=lo_o=0, stall_req_o=0. Then we_i=1, hi_i=0x12345678, lo_i=0x9ABCDEF0 → both values visible on the next cycle.
- DIVU 100/7 → stall_req_o high cycles 0–32, div_done_o at cycle 33; cycle 34: LO=14, HI=2. Separately, DIVU 0xFFFFFFFF/1 → LO=0xFFFFFFFF, HI=0.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/−2 → LO=0xFFFFFFFD, HI=1. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- Divisor 0, with HI/LO preloaded to 0x11/0x22 → div_done_o at cycle 1, stall released at cycle 2, HI/LO still 0x11/0x22.
- DIVU 100/7 with annul_i pulsed at cycle 10 → IDLE at cycle 11, no div_done_o, HI/LO unchanged, stall_req_o=0 from cycle 11.
- we_i=1 (hi_i=0xAAAA, lo_i=0xBBBB) in the END cycle of DIVU 100/7 → HI=2, LO=14. Then async rst asserted mid-ON → immediate IDLE, hi_o=lo_o=0.
